// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs,
// ALU codes and datapath mux selects.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned ALUF_W  = 4;
  localparam int unsigned STATE_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_EXEC_R   = 4'd3;
  localparam state_t S_EXEC_I   = 4'd4;
  localparam state_t S_ADDR     = 4'd5;
  localparam state_t S_MEM_RD   = 4'd6;
  localparam state_t S_MEM_WR   = 4'd7;
  localparam state_t S_WB_R     = 4'd8;
  localparam state_t S_WB_I     = 4'd9;
  localparam state_t S_WB_MEM   = 4'd10;
  localparam state_t S_BRANCH   = 4'd11;
  localparam state_t S_JUMP     = 4'd12;
  localparam state_t S_JUMP_REG = 4'd13;
  localparam state_t S_TRAP     = 4'd14;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FN_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FN_W-1:0] FN_SRL = 6'b000010;
  localparam logic [FN_W-1:0] FN_JR  = 6'b001000;
  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUF_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUF_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUF_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALUF_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUF_W-1:0] ALU_SLT = 4'd4;
  localparam logic [ALUF_W-1:0] ALU_SLL = 4'd5;
  localparam logic [ALUF_W-1:0] ALU_SRL = 4'd6;
  localparam logic [ALUF_W-1:0] ALU_LUI = 4'd7;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // R-type functs that run through EXEC_R (jr is dispatched separately)
  function automatic logic is_alu_funct(input logic [FN_W-1:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ALUF_W-1:0] alu_from_funct(input logic [FN_W-1:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [ALUF_W-1:0] alu_from_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath/memory-port signal bundle; master is the controller.
interface mc_control_if;
  import mips_pkg::*;

  logic [OP_W-1:0]   opcode;
  logic [FN_W-1:0]   funct;
  logic              alu_zero;
  logic              mem_ready;
  logic              mem_req;
  logic              mem_we;
  logic              ir_we;
  logic              mdr_we;
  logic              pc_we;
  logic [1:0]        pc_src;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic              imm_zext;
  logic [ALUF_W-1:0] alufunc;
  logic              reg_we;
  logic [1:0]        reg_dst;
  logic [1:0]        wb_sel;
  logic              instr_done;
  logic              halt;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, ir_we, mdr_we, pc_we, pc_src, alu_src_a, alu_src_b,
           imm_zext, alufunc, reg_we, reg_dst, wb_sel, instr_done, halt
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, ir_we, mdr_we, pc_we, pc_src, alu_src_a, alu_src_b,
           imm_zext, alufunc, reg_we, reg_dst, wb_sel, instr_done, halt
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS sequencing FSM: Moore decode of the state drives every datapath
// enable/select; a saturating counter optionally bounds the fetch wait.
module mc_control
  import mips_pkg::*;
#(
  parameter int unsigned FETCH_WAIT_MAX = 0
) (
  input logic          clk,
  input logic          rst,
  mc_control_if.master bus
);

  localparam int unsigned WAIT_LAST = (FETCH_WAIT_MAX == 0) ? 0 : FETCH_WAIT_MAX - 1;
  localparam int unsigned WAIT_W    = (WAIT_LAST < 2) ? 1 : $clog2(WAIT_LAST + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_c;

  logic              mem_req_c, mem_we_c, ir_we_c, mdr_we_c, pc_we_c;
  logic [1:0]        pc_src_c, alu_src_b_c, reg_dst_c, wb_sel_c;
  logic              alu_src_a_c, imm_zext_c, reg_we_c, instr_done_c, halt_c;
  logic [ALUF_W-1:0] alufunc_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Counts unacknowledged fetch cycles; the last count value traps if still not ready
  assign timeout_c = (FETCH_WAIT_MAX != 0) && (wait_q == WAIT_W'(WAIT_LAST));

  always_comb begin
    wait_d = wait_q;
    if (state_q != S_FETCH && state_d == S_FETCH) begin
      wait_d = '0;
    end else if (state_q == S_FETCH && !bus.mem_ready && wait_q != WAIT_W'(WAIT_LAST)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_we_c      = 1'b0;
    mdr_we_c     = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = PC_ALU;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_REG;
    imm_zext_c   = 1'b0;
    alufunc_c    = ALU_ADD;
    reg_we_c     = 1'b0;
    reg_dst_c    = DST_RT;
    wb_sel_c     = WB_ALUOUT;
    instr_done_c = 1'b0;
    halt_c       = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b_c = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.funct == FN_JR)          state_d = S_JUMP_REG;
            else if (is_alu_funct(bus.funct)) state_d = S_EXEC_R;
            else                             state_d = S_TRAP;
          end
          OP_LW, OP_SW:                              state_d = S_ADDR;
          OP_BEQ, OP_BNE:                            state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = S_EXEC_I;
          OP_J, OP_JAL:                              state_d = S_JUMP;
          default:                                   state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alufunc_c   = alu_from_funct(bus.funct);
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        reg_we_c     = 1'b1;
        reg_dst_c    = DST_RD;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alufunc_c   = alu_from_op(bus.opcode);
        imm_zext_c  = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
        state_d     = S_WB_I;
      end
      S_WB_I: begin
        reg_we_c     = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          mdr_we_c = 1'b1;
          state_d  = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        reg_we_c     = 1'b1;
        wb_sel_c     = WB_MDR;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        if (bus.mem_ready) begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a_c  = 1'b1;
        alufunc_c    = ALU_SUB;
        pc_src_c     = PC_ALUOUT;
        pc_we_c      = bus.alu_zero ^ (bus.opcode == OP_BNE);
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_we_c      = 1'b1;
        pc_src_c     = PC_JUMP;
        instr_done_c = 1'b1;
        // jal links the already-incremented PC into r31
        if (bus.opcode == OP_JAL) begin
          reg_we_c  = 1'b1;
          reg_dst_c = DST_R31;
          wb_sel_c  = WB_PC;
        end
        state_d = S_FETCH;
      end
      S_JUMP_REG: begin
        pc_we_c      = 1'b1;
        pc_src_c     = PC_RS;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP:  halt_c = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req    = mem_req_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.ir_we      = ir_we_c;
  assign bus.mdr_we     = mdr_we_c;
  assign bus.pc_we      = pc_we_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.imm_zext   = imm_zext_c;
  assign bus.alufunc    = alufunc_c;
  assign bus.reg_we     = reg_we_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.wb_sel     = wb_sel_c;
  assign bus.instr_done = instr_done_c;
  assign bus.halt       = halt_c;

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle sequencing controller for the 32-bit MIPS datapath. It takes the opcode and funct fields that the instruction decoder splits out of the instruction register. From these it steps the shared ALU, register file, PC and single memory port through fetch, decode, execute, memory and writeback. It issues every datapath enable and mux select, and it owns the request/ready handshake to the memory port.

## Interface
- `FETCH_WAIT_MAX`, default 0: 0 means wait forever for `mem_ready`. N>0 means a fetch not acknowledged within N cycles goes to TRAP.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `opcode` in 6: instruction bits 31:26 from the decoder. Valid from DECODE onward.
- `funct` in 6: instruction bits 5:0.
- `alu_zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory port completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = write (sw), 0 = read.
- `ir_we` out 1: load the instruction register.
- `mdr_we` out 1: load the memory data register.
- `pc_we` out 1: PC write enable.
- `pc_src` out 2: 0 ALU result, 1 ALUOut (branch target), 2 jump target {PC[31:28], imm_j, 00}, 3 rs.
- `alu_src_a` out 1: 0 PC, 1 register A.
- `alu_src_b` out 2: 0 register B, 1 constant 4, 2 extended imm, 3 sign-extended imm << 2.
- `imm_zext` out 1: zero-extend the immediate (andi, ori).
- `alufunc` out 4: ALU operation code.
- `reg_we` out 1: register file write enable.
- `reg_dst` out 2: 0 rt, 1 rd, 2 r31.
- `wb_sel` out 2: 0 ALUOut, 1 MDR, 2 PC.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `halt` out 1: sticky; set in TRAP.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, JUMP_REG, TRAP.
- Outputs are Moore decodes of the state. `alufunc` and `imm_zext` additionally depend on `opcode`/`funct` in EXEC_R and EXEC_I.
- Any output not listed for a state is 0.
- `alufunc` codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI. Codes 8-15 are unused.
- **IDLE**: all outputs 0. Next state FETCH.
- **FETCH**: `mem_req`=1, `alu_src_a`=0, `alu_src_b`=1, ADD. When `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=0, then go to DECODE. Otherwise stay in FETCH.
- **DECODE**: ALU computes the branch target (`alu_src_a`=0, `alu_src_b`=3, ADD). Dispatch on opcode:
  - 000000 R-type: funct 001000 (jr) → JUMP_REG; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000010 srl → EXEC_R; any other funct → TRAP.
  - 100011 lw, 101011 sw → ADDR.
  - 000100 beq, 000101 bne → BRANCH.
  - 001000 addi, 001100 andi, 001101 ori, 001010 slti, 001111 lui → EXEC_I.
  - 000010 j, 000011 jal → JUMP.
  - Any other opcode → TRAP.
- **EXEC_R** → WB_R: `alu_src_a`=1, `alu_src_b`=0, `alufunc` from funct.
- **WB_R**: `reg_we`, `reg_dst`=1, `wb_sel`=0, `instr_done`. Next state FETCH.
- **EXEC_I** → WB_I: `alu_src_a`=1, `alu_src_b`=2, `alufunc` from opcode; `imm_zext` for andi/ori.
- **WB_I**: `reg_we`, `reg_dst`=0, `wb_sel`=0, `instr_done`. Next state FETCH.
- **ADDR**: `alu_src_a`=1, `alu_src_b`=2, ADD. Next state MEM_RD (lw) or MEM_WR (sw).
- **MEM_RD**: `mem_req`=1, `mem_we`=0. On `mem_ready`: `mdr_we`, then go to WB_MEM.
- **WB_MEM**: `reg_we`, `reg_dst`=0, `wb_sel`=1, `instr_done`. Next state FETCH.
- **MEM_WR**: `mem_req`=1, `mem_we`=1. On `mem_ready`: `instr_done`, then go to FETCH.
- **BRANCH**: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_src`=1. `pc_we` = `alu_zero` XOR (opcode==bne). `instr_done`. Next state FETCH.
- **JUMP**: `pc_we`, `pc_src`=2, `instr_done`. For jal, also `reg_we`, `reg_dst`=2, `wb_sel`=2; the PC written is the already-incremented PC+4. Next state FETCH.
- **JUMP_REG**: `pc_we`, `pc_src`=3, `instr_done`. Next state FETCH.
- **TRAP**: `halt`=1, all other outputs 0. Stays in TRAP until `rst`.

## Timing
- Under `rst`, the state goes to IDLE on the next edge, which mid-operation includes a pending request. All outputs are 0 in the first cycle after reset, including `halt`; `mem_req` is deasserted with no completion.
- Latency with zero-wait memory: R-type and I-type 4 cycles; lw 5; sw 4; branch 3; j, jal, jr 3.
- Each `mem_ready`-low cycle during a memory access adds one cycle.
- Handshake:
  - `mem_req` and `mem_we` are held stable until `mem_ready` is sampled high.
  - The transfer completes in that cycle.
  - `mem_ready` with `mem_req`=0 is ignored.
  - Back-to-back requests (MEM_WR → FETCH) keep `mem_req` high across the boundary.
- `FETCH_WAIT_MAX`: the wait counter is cleared on entering FETCH and saturates. Reaching N with `mem_ready` low → TRAP.
- `pc_we` never asserts in the same cycle as `reg_we`, except for jal.

## Structure
- Package `mips_pkg`: state enum, opcode/funct localparams, `alufunc` codes, and encodings for `pc_src`, `alu_src_b`, `reg_dst` and `wb_sel`.
- No sub-module. The controller is one FSM plus the fetch-timeout counter.

## Test plan
- Reset, then `add` (opcode 0, funct 0x20), `mem_ready`=1 → `ir_we` and `pc_we` in cycle 1; `reg_we`, `reg_dst`=1 and `instr_done` in cycle 4.
- `lw` with `mem_ready` low for 3 cycles in MEM_RD → `mem_req` held high for 4 cycles; `mdr_we` once; `instr_done` in cycle 8.
- `beq` with `alu_zero`=1, then `bne` with `alu_zero`=1 → `pc_we`=1 then `pc_we`=0, both in cycle 3.
- `jal` → cycle 3 shows `pc_src`=2, `reg_dst`=2, `wb_sel`=2, `reg_we`=1.
- Opcode 0x3F, and opcode 0 with funct 0x3F → `halt` from cycle 3 onward, held until `rst`, which clears it.
- `rst` asserted in MEM_WR while `mem_ready`=0 → `mem_req`=0 next cycle, FETCH one cycle later; with `FETCH_WAIT_MAX`=4 and `mem_ready` stuck low → TRAP.
